// File: rtl/half_fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : half_fp_pkg
// Description : Shared constants, flag bit positions and FSM state encoding
//               for the binary16 post-add/sub normalize-and-round stage.
// Revision    : 1.0 - initial release
// ============================================================================
package half_fp_pkg;

    // Format constants
    localparam int HALF_BIAS    = 15;
    localparam int HALF_EXP_MAX = 31;

    // Magnitude encodings (sign bit is prepended by the user)
    localparam logic [14:0] MAG_INF  = 15'h7C00;
    localparam logic [14:0] MAG_ZERO = 15'h0000;

    // Exception flag bit positions within FLAGS
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_UF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_NX = 0;

    // Normalizer control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/half_rne_round.sv
`default_nettype none
// ============================================================================
// Module      : half_rne_round
// Description : Combinational round-to-nearest-even and binary16 packing of a
//               normalized (or subnormal) working mantissa.
// Revision    : 1.0 - initial release
// ============================================================================
module half_rne_round
    import half_fp_pkg::*;
#(
    parameter int EXP_LIMIT = HALF_EXP_MAX
) (
    input  logic        i_sign,
    input  logic [13:0] i_w,
    input  logic [5:0]  i_e,
    output logic [15:0] o_q,
    output logic        o_nx,
    output logic        o_of,
    output logic        o_carry
);

    logic        w_guard;
    logic        w_sticky;
    logic        w_round_up;
    logic [11:0] w_sum;
    logic [10:0] w_m;
    logic [5:0]  w_e_adj;
    logic [4:0]  w_exp_enc;

    // Round the 11-bit significand and encode; a significand that is still
    // below the hidden bit after rounding is emitted with exponent field 0.
    always_comb begin
        w_guard    = i_w[2];
        w_sticky   = i_w[1] | i_w[0];
        w_round_up = w_guard & (i_w[3] | w_sticky);
        w_sum      = {1'b0, i_w[13:3]} + {11'd0, w_round_up};
        o_carry    = w_sum[11];
        w_m        = o_carry ? w_sum[11:1] : w_sum[10:0];
        w_e_adj    = i_e + {5'd0, o_carry};
        w_exp_enc  = w_m[10] ? w_e_adj[4:0] : 5'd0;
        o_of       = (w_e_adj >= 6'(EXP_LIMIT));
        o_nx       = w_guard | w_sticky | o_of;
        o_q        = o_of ? {i_sign, MAG_INF} : {i_sign, w_exp_enc, w_m[9:0]};
    end

endmodule
`default_nettype wire

// File: rtl/half_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : half_norm_round
// Description : Iterative (one bit per cycle) normalizer followed by a single
//               RNE rounding cycle; emits a binary16 word plus exception flags
//               behind valid/ready handshakes. One operation in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module half_norm_round
    import half_fp_pkg::*;
#(
    parameter int EXP_W  = 5,
    parameter int FRAC_W = 10,
    parameter int BIAS   = 15
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  IN_SIGN,
    input  logic [EXP_W-1:0]      IN_EXP_HALF,
    input  logic [FRAC_W+1:0]     IN_MANT,
    input  logic [2:0]            IN_GRS,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [EXP_W+FRAC_W:0] Q,
    output logic [4:0]            FLAGS
);

    localparam int               c_w_width = FRAC_W + 5;
    localparam logic [EXP_W:0]   c_e_one   = {{EXP_W{1'b0}}, 1'b1};

    state_t                      r_state;
    logic [c_w_width-1:0]        r_w;
    logic [EXP_W:0]              r_e;
    logic                        r_s;
    logic [EXP_W+FRAC_W:0]       r_q;
    logic [4:0]                  r_flags;
    logic                        r_out_valid;

    logic [EXP_W+FRAC_W:0]       w_rnd_q;
    logic                        w_rnd_nx;
    logic                        w_rnd_of;
    logic                        w_rnd_carry;
    logic [4:0]                  w_flags;
    logic                        w_w_zero;

    assign w_w_zero  = (r_w == '0);
    assign IN_READY  = (r_state == ST_IDLE) & ~RST;
    assign OUT_VALID = r_out_valid;
    assign Q         = r_q;
    assign FLAGS     = r_flags;

    // Overflow threshold is the all-ones biased exponent
    half_rne_round #(
        .EXP_LIMIT (2 * BIAS + 1)
    ) u_round (
        .i_sign  (r_s),
        .i_w     (r_w[13:0]),
        .i_e     (r_e),
        .o_q     (w_rnd_q),
        .o_nx    (w_rnd_nx),
        .o_of    (w_rnd_of),
        .o_carry (w_rnd_carry)
    );

    // Flag vector for a nonzero result; tiny means hidden bit still clear
    always_comb begin
        w_flags          = '0;
        w_flags[FLAG_NX] = w_rnd_nx;
        w_flags[FLAG_OF] = w_rnd_of;
        w_flags[FLAG_UF] = w_rnd_nx & ~r_w[13];
    end

    // Control FSM, shifter and registered result
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_w         <= '0;
            r_e         <= '0;
            r_s         <= 1'b0;
            r_q         <= '0;
            r_flags     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (IN_VALID) begin
                        r_w     <= {IN_MANT, IN_GRS};
                        r_e     <= (IN_EXP_HALF == '0) ? c_e_one : {1'b0, IN_EXP_HALF};
                        r_s     <= IN_SIGN;
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    if (w_w_zero) begin
                        r_e     <= '0;
                        r_state <= ST_ROUND;
                    end else if (r_w[14]) begin
                        // Carry out of the adder: fold the dropped bit into sticky
                        r_w <= {1'b0, r_w[14:2], r_w[1] | r_w[0]};
                        r_e <= r_e + c_e_one;
                    end else if (!r_w[13] && (r_e > c_e_one)) begin
                        r_w <= r_w << 1;
                        r_e <= r_e - c_e_one;
                    end else begin
                        r_state <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    if (w_w_zero) begin
                        r_q     <= {r_s, MAG_ZERO};
                        r_flags <= '0;
                    end else begin
                        r_q     <= w_rnd_q;
                        r_flags <= w_flags;
                    end
                    r_e         <= r_e + {{EXP_W{1'b0}}, w_rnd_carry};
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (OUT_READY) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_half_norm_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_half_norm_round
// Description : Self-checking bench for half_norm_round. Expected results come
//               from an arithmetic value model of RNE binary16 rounding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_half_norm_round;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic        IN_SIGN;
    logic [4:0]  IN_EXP_HALF;
    logic [11:0] IN_MANT;
    logic [2:0]  IN_GRS;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] Q;
    logic [4:0]  FLAGS;

    int n_tests = 0;
    int n_fail  = 0;

    logic [20:0] exp_q[$];   // {Q, FLAGS} expected for the result in flight

    typedef struct {
        logic        s;
        logic [4:0]  e;
        logic [11:0] m;
        logic [2:0]  g;
        logic [15:0] q;
        logic [4:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    half_norm_round dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_SIGN     (IN_SIGN),
        .IN_EXP_HALF (IN_EXP_HALF),
        .IN_MANT     (IN_MANT),
        .IN_GRS      (IN_GRS),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .Q           (Q),
        .FLAGS       (FLAGS)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Value model: the operand is W * 2^(E-28) with W = {mant, grs}; round it
    // to the nearest representable binary16 value (ties to even).
    task automatic model(input logic s, input logic [4:0] e, input logic [11:0] m,
                         input logic [2:0] g, output logic [15:0] q,
                         output logic [4:0] f, output int lat);
        int w, ee, p, be, x, lx, idx, keep, rem, half, bexp;
        bit up, tiny, of, nx;
        w   = int'({m, g});
        ee  = (e == 5'd0) ? 1 : int'(e);
        q   = {s, 15'h0};
        f   = 5'd0;
        lat = 2;
        if (w != 0) begin
            p = 0;
            for (int i = 0; i < 15; i++) if (w[i]) p = i;
            be   = p - 13 + ee;               // biased exponent of leading one
            tiny = (be < 1);
            x    = be - 15;
            lx   = ((x > -14) ? x : -14) - 10; // exponent of result LSB
            idx  = lx + 28 - ee;              // its bit position within W
            if (idx > 0) begin
                keep = w >> idx;
                rem  = w & ((1 << idx) - 1);
                half = 1 << (idx - 1);
                up   = (rem > half) || ((rem == half) && keep[0]);
            end else begin
                keep = w << (-idx);
                rem  = 0;
                up   = 1'b0;
            end
            keep = keep + int'(up);
            if (keep >= 2048) begin
                keep = keep >> 1;
                lx   = lx + 1;
            end
            if (keep >= 1024) begin
                bexp = lx + 25;
                keep = keep - 1024;
            end else begin
                bexp = 0;
            end
            of = (bexp >= 31);
            nx = (rem != 0) || of;
            q  = of ? {s, 5'h1F, 10'h000} : {s, bexp[4:0], keep[9:0]};
            f  = {2'b00, nx & tiny, of, nx};
            if (p == 14) lat = 3;
            else lat = 2 + (((13 - p) < (ee - 1)) ? (13 - p) : (ee - 1));
        end
    endtask

    // Compare process: every cycle a result is presented it must match
    always @(negedge CLK) begin
        if (!RST && OUT_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_out: got Q=%h FLAGS=%b, expected no result", Q, FLAGS);
            end else begin
                check("q_vs_model", 32'(Q), 32'(exp_q[0][20:5]));
                check("flags_vs_model", 32'(FLAGS), 32'(exp_q[0][4:0]));
                if (OUT_READY) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic s, input logic [4:0] e, input logic [11:0] m,
                         input logic [2:0] g, input bit use_lit, input logic [15:0] lq,
                         input logic [4:0] lf, input int llat, input int hold);
        logic [15:0] mq;
        logic [4:0]  mf;
        int          mlat;
        int          cnt;
        model(s, e, m, g, mq, mf, mlat);
        if (use_lit) begin
            check("lit_q", 32'(mq), 32'(lq));
            check("lit_flags", 32'(mf), 32'(lf));
            check("lit_latency", mlat, llat);
        end
        exp_q.push_back({mq, mf});
        cnt = 0;
        while (IN_READY !== 1'b1 && cnt < 50) begin
            @(posedge CLK); #1; cnt++;
        end
        check("in_ready_before_op", 32'(IN_READY), 32'd1);
        IN_VALID    = 1'b1;
        IN_SIGN     = s;
        IN_EXP_HALF = e;
        IN_MANT     = m;
        IN_GRS      = g;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        cnt = 0;
        while (OUT_VALID !== 1'b1 && cnt < 40) begin
            @(posedge CLK); #1; cnt++;
        end
        check("latency", cnt, mlat);
        if (OUT_VALID !== 1'b1) begin
            exp_q.delete();
            return;
        end
        repeat (hold) begin
            @(posedge CLK); #1;
            check("hold_out_valid", 32'(OUT_VALID), 32'd1);
            check("hold_in_ready", 32'(IN_READY), 32'd0);
        end
        OUT_READY = 1'b1;
        @(posedge CLK); #1;
        OUT_READY = 1'b0;
        check("release_out_valid", 32'(OUT_VALID), 32'd0);
        check("release_in_ready", 32'(IN_READY), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        IN_SIGN = 1'b0; IN_EXP_HALF = 5'd0; IN_MANT = 12'h0; IN_GRS = 3'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_q", 32'(Q), 32'd0);
        check("rst_flags", 32'(FLAGS), 32'd0);
        check("rst_in_ready", 32'(IN_READY), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("idle_in_ready", 32'(IN_READY), 32'd1);

        //                s     e       mant     grs     Q        FLAGS   lat
        vecs.push_back('{1'b0, 5'd15, 12'h800, 3'b000, 16'h4000, 5'h00, 3});
        vecs.push_back('{1'b0, 5'd15, 12'h001, 3'b000, 16'h1400, 5'h00, 12});
        vecs.push_back('{1'b0, 5'd15, 12'h401, 3'b100, 16'h3C02, 5'h01, 2});
        vecs.push_back('{1'b0, 5'd15, 12'h400, 3'b100, 16'h3C00, 5'h01, 2});
        vecs.push_back('{1'b0, 5'd30, 12'h800, 3'b000, 16'h7C00, 5'h03, 3});
        vecs.push_back('{1'b1, 5'd30, 12'h800, 3'b000, 16'hFC00, 5'h03, 3});
        vecs.push_back('{1'b0, 5'd3,  12'h001, 3'b001, 16'h0004, 5'h05, 4});
        vecs.push_back('{1'b0, 5'd3,  12'h001, 3'b000, 16'h0004, 5'h00, 4});
        vecs.push_back('{1'b1, 5'd15, 12'h000, 3'b000, 16'h8000, 5'h00, 2});
        vecs.push_back('{1'b0, 5'd0,  12'h200, 3'b000, 16'h0200, 5'h00, 2});
        vecs.push_back('{1'b0, 5'd1,  12'h3FF, 3'b100, 16'h0400, 5'h05, 2});
        vecs.push_back('{1'b0, 5'd15, 12'h7FF, 3'b100, 16'h4000, 5'h01, 2});
        vecs.push_back('{1'b0, 5'd30, 12'h7FF, 3'b110, 16'h7C00, 5'h03, 2});
        vecs.push_back('{1'b0, 5'd15, 12'hC01, 3'b000, 16'h4200, 5'h01, 3});

        // First vector also exercises a 5-cycle downstream stall
        foreach (vecs[i])
            do_op(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].g, 1'b1,
                  vecs[i].q, vecs[i].f, vecs[i].lat, (i == 0) ? 5 : 0);

        for (int i = 0; i < 30; i++) begin
            logic [11:0] rm;
            rm = 12'($urandom_range(0, 4095) >> $urandom_range(0, 11));
            do_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), rm,
                  3'($urandom_range(0, 7)), 1'b0, 16'h0, 5'h0, 0,
                  int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a long normalization discards the operation
        IN_VALID = 1'b1; IN_SIGN = 1'b0; IN_EXP_HALF = 5'd15;
        IN_MANT = 12'h001; IN_GRS = 3'b000;
        @(posedge CLK); #1;
        IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("norm_in_ready", 32'(IN_READY), 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;
        check("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        check("midrst_q", 32'(Q), 32'd0);
        check("midrst_flags", 32'(FLAGS), 32'd0);
        check("midrst_in_ready", 32'(IN_READY), 32'd0);
        RST = 1'b0;
        #1;
        check("after_rst_in_ready", 32'(IN_READY), 32'd1);
        begin
            int seen;
            seen = 0;
            repeat (15) begin
                @(posedge CLK); #1;
                if (OUT_VALID !== 1'b0) seen++;
            end
            check("no_result_after_rst", seen, 0);
        end

        // Pipeline still usable after the abort
        do_op(1'b0, 5'd15, 12'h800, 3'b000, 1'b1, 16'h4000, 5'h00, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
